// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive-side frame controller.
package uart_rx_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

   localparam logic [4:0] PRESCALE_8  = 5'd8;
   localparam logic [4:0] PRESCALE_16 = 5'd16;

   // Mid-bit sample edges M-1, M, M+1 with M = Prescale/2
   localparam logic [3:0] SMP_EARLY_P8  = 4'd3;
   localparam logic [3:0] SMP_MID_P8    = 4'd4;
   localparam logic [3:0] SMP_LATE_P8   = 4'd5;
   localparam logic [3:0] SMP_EARLY_P16 = 4'd7;
   localparam logic [3:0] SMP_MID_P16   = 4'd8;
   localparam logic [3:0] SMP_LATE_P16  = 4'd9;

   function automatic logic prescale_ok(input logic [4:0] prescale);
      return (prescale == PRESCALE_8) || (prescale == PRESCALE_16);
   endfunction

   // Bits per frame: start + data + optional parity + stop
   function automatic int unsigned frame_bits(input int unsigned data_width, input logic par_en);
      return 32'd2 + data_width + 32'(par_en);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Three mid-bit sample registers and a majority vote over them.
module uart_rx_sampler
   import uart_rx_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       rx,
   input  logic [4:0] prescale,
   input  logic [3:0] edge_cnt,
   output logic       bit_val
);

   logic [2:0] smp;
   logic       p16;
   logic [3:0] e_early, e_mid, e_late;

   assign p16     = (prescale == PRESCALE_16);
   assign e_early = p16 ? SMP_EARLY_P16 : SMP_EARLY_P8;
   assign e_mid   = p16 ? SMP_MID_P16   : SMP_MID_P8;
   assign e_late  = p16 ? SMP_LATE_P16  : SMP_LATE_P8;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         smp <= '0;
      end else if (clr) begin
         smp <= '0;
      end else begin
         if (edge_cnt == e_early) smp[0] <= rx;
         if (edge_cnt == e_mid)   smp[1] <= rx;
         if (edge_cnt == e_late)  smp[2] <= rx;
      end
   end

   assign bit_val = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX frame controller: sequences the external edge/bit counter and
// assembles, parity-checks and stop-checks one frame at a time.
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
)
(
   input  logic                  CLK_rx_ctrl,
   input  logic                  RST_rx_ctrl,
   input  logic                  RX_IN_rx_ctrl,
   input  logic [4:0]            Prescale_rx_ctrl,
   input  logic                  PAR_EN_rx_ctrl,
   input  logic                  PAR_TYP_rx_ctrl,
   input  logic [3:0]            bit_cnt_rx_ctrl,
   input  logic [3:0]            edge_cnt_rx_ctrl,
   output logic                  cnt_en_rx_ctrl,
   output logic [DATA_WIDTH-1:0] P_DATA_rx_ctrl,
   output logic                  data_valid_rx_ctrl,
   output logic                  par_err_rx_ctrl,
   output logic                  stp_err_rx_ctrl
);

   localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);

   rx_state_t             state, state_nxt;
   logic                  bit_val, bit_end, legal;
   logic                  start_entry, shift_en, par_chk;
   logic                  dv_nxt, pe_nxt, se_nxt;
   logic                  par_bad;
   logic [DATA_WIDTH-1:0] shift;

   assign legal          = prescale_ok(Prescale_rx_ctrl);
   assign bit_end        = ({1'b0, edge_cnt_rx_ctrl} == (Prescale_rx_ctrl - 5'd1));
   assign cnt_en_rx_ctrl = (state != IDLE);

   uart_rx_sampler u_sampler (
      .clk      (CLK_rx_ctrl),
      .rst      (RST_rx_ctrl),
      .clr      (start_entry),
      .rx       (RX_IN_rx_ctrl),
      .prescale (Prescale_rx_ctrl),
      .edge_cnt (edge_cnt_rx_ctrl),
      .bit_val  (bit_val)
   );

   always_ff @(posedge CLK_rx_ctrl or posedge RST_rx_ctrl) begin
      if (RST_rx_ctrl) state <= IDLE;
      else             state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      start_entry = 1'b0;
      shift_en    = 1'b0;
      par_chk     = 1'b0;
      dv_nxt      = 1'b0;
      pe_nxt      = 1'b0;
      se_nxt      = 1'b0;
      case (state)
         IDLE: begin
            if (!RX_IN_rx_ctrl && legal) begin
               state_nxt   = START;
               start_entry = 1'b1;
            end
         end
         START: begin
            if (bit_end) state_nxt = bit_val ? IDLE : DATA;
         end
         DATA: begin
            if (bit_end) begin
               shift_en = 1'b1;
               if (bit_cnt_rx_ctrl == LAST_DATA) state_nxt = PAR_EN_rx_ctrl ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (bit_end) begin
               par_chk   = 1'b1;
               state_nxt = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_nxt = IDLE;
               dv_nxt    = bit_val && !par_bad;
               se_nxt    = !bit_val;
               pe_nxt    = par_bad;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // An illegal prescale mid-frame makes the counter timing meaningless: drop the frame silently
      if (state != IDLE && !legal) begin
         state_nxt = IDLE;
         shift_en  = 1'b0;
         par_chk   = 1'b0;
         dv_nxt    = 1'b0;
         pe_nxt    = 1'b0;
         se_nxt    = 1'b0;
      end
   end

   always_ff @(posedge CLK_rx_ctrl or posedge RST_rx_ctrl) begin
      if (RST_rx_ctrl) begin
         shift              <= '0;
         par_bad            <= 1'b0;
         P_DATA_rx_ctrl     <= '0;
         data_valid_rx_ctrl <= 1'b0;
         par_err_rx_ctrl    <= 1'b0;
         stp_err_rx_ctrl    <= 1'b0;
      end else begin
         data_valid_rx_ctrl <= dv_nxt;
         par_err_rx_ctrl    <= pe_nxt;
         stp_err_rx_ctrl    <= se_nxt;
         if (start_entry) par_bad <= 1'b0;
         if (shift_en)    shift   <= {bit_val, shift[DATA_WIDTH-1:1]};
         if (par_chk)     par_bad <= bit_val ^ (^shift) ^ PAR_TYP_rx_ctrl;
         if (dv_nxt)      P_DATA_rx_ctrl <= shift;
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Frame-level bench for uart_rx_ctrl: per-cycle scoreboard plus directed literal checks.
module tb_uart_rx_ctrl;
   import uart_rx_pkg::*;

   localparam int DW    = 8;
   localparam int DEPTH = 4096;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rx = 1'b1;
   logic          par_en = 1'b0;
   logic          par_typ = 1'b0;
   logic [4:0]    prescale = 5'd16;
   logic [3:0]    bit_cnt = 4'd0;
   logic [3:0]    edge_cnt = 4'd0;
   logic          cnt_en;
   logic [DW-1:0] p_data;
   logic          dv, pe, se;

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   bit run = 1'b0;

   bit          exp_busy [DEPTH];
   bit          exp_dv   [DEPTH];
   bit          exp_pe   [DEPTH];
   bit          exp_se   [DEPTH];
   bit [DW-1:0] exp_word [DEPTH];
   bit [DW-1:0] held = '0;
   int          idle_from = 0;

   uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
      .CLK_rx_ctrl        (clk),
      .RST_rx_ctrl        (rst),
      .RX_IN_rx_ctrl      (rx),
      .Prescale_rx_ctrl   (prescale),
      .PAR_EN_rx_ctrl     (par_en),
      .PAR_TYP_rx_ctrl    (par_typ),
      .bit_cnt_rx_ctrl    (bit_cnt),
      .edge_cnt_rx_ctrl   (edge_cnt),
      .cnt_en_rx_ctrl     (cnt_en),
      .P_DATA_rx_ctrl     (p_data),
      .data_valid_rx_ctrl (dv),
      .par_err_rx_ctrl    (pe),
      .stp_err_rx_ctrl    (se)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Edge/bit counter beside the controller
   always @(posedge clk) begin
      if (cnt_en !== 1'b1) begin
         edge_cnt <= 4'd0;
         bit_cnt  <= 4'd0;
      end else if ({1'b0, edge_cnt} == prescale - 5'd1) begin
         edge_cnt <= 4'd0;
         bit_cnt  <= bit_cnt + 4'd1;
      end else begin
         edge_cnt <= edge_cnt + 4'd1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s at cycle %0d: got %0h, wanted %0h", name, cyc, act, exp);
      end
   endtask

   // Per-cycle scoreboard
   always @(negedge clk) begin
      if (run && cyc < DEPTH) begin
         if (rst) begin
            held = '0;
            chk("rst_cnt_en", 32'(cnt_en), 0);
            chk("rst_dv", 32'(dv), 0);
            chk("rst_pe", 32'(pe), 0);
            chk("rst_se", 32'(se), 0);
            chk("rst_pdata", 32'(p_data), 0);
         end else begin
            if (exp_dv[cyc]) held = exp_word[cyc];
            chk("cnt_en", 32'(cnt_en), 32'(exp_busy[cyc]));
            chk("data_valid", 32'(dv), 32'(exp_dv[cyc]));
            chk("par_err", 32'(pe), 32'(exp_pe[cyc]));
            chk("stp_err", 32'(se), 32'(exp_se[cyc]));
            chk("p_data", 32'(p_data), 32'(held));
         end
      end
   end

   // Model: a frame whose line goes low at s is seen at the first IDLE cycle t0 >= s;
   // busy t0+1..t0+N*P, outcome pulse at t0+N*P+1.
   task automatic sched_frame(input int s, input int p, input bit pen, input bit [DW-1:0] word,
                              input bit parb, input bit stop, output int t_res);
      int t0, n;
      bit pbad;
      t0   = (s > idle_from) ? s : idle_from;
      n    = int'(frame_bits(DW, pen));
      pbad = pen && (parb != ((^word) ^ par_typ));
      for (int c = t0 + 1; c <= t0 + n * p; c++) exp_busy[c] = 1'b1;
      t_res = t0 + n * p + 1;
      exp_dv[t_res]   = stop && !pbad;
      exp_pe[t_res]   = pbad;
      exp_se[t_res]   = !stop;
      exp_word[t_res] = word;
      idle_from = t_res;
   endtask

   // Model: line low for low_len cycles from s; start bit judged by majority at mid-bit.
   task automatic sched_glitch(input int s, input int low_len, input int p, output int t_idle);
      int t0, m, ones;
      t0   = (s > idle_from) ? s : idle_from;
      m    = p / 2;
      ones = 0;
      for (int e = m - 1; e <= m + 1; e++) if ((t0 + 1 + e) - s >= low_len) ones++;
      if (ones >= 2) begin
         for (int c = t0 + 1; c <= t0 + p; c++) exp_busy[c] = 1'b1;
         t_idle = t0 + p + 1;
      end else begin
         t_idle = -1;
      end
      idle_from = t_idle;
   endtask

   task automatic abort_from(input int r);
      for (int c = r; c < DEPTH; c++) begin
         exp_busy[c] = 1'b0;
         exp_dv[c]   = 1'b0;
         exp_pe[c]   = 1'b0;
         exp_se[c]   = 1'b0;
      end
      idle_from = r;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic at(input int c);
      while (cyc < c) step(1);
   endtask

   task automatic send(input bit [DW-1:0] word, input bit pen, input bit parb, input bit stop, input int p);
      rx = 1'b0;
      step(p);
      for (int i = 0; i < DW; i++) begin
         rx = word[i];
         step(p);
      end
      if (pen) begin
         rx = parb;
         step(p);
      end
      rx = stop;
      step(p);
      rx = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int s, tr, tr2, r;
      @(posedge clk);
      #1;
      run = 1'b1;
      step(2);
      chk("reset_cnt_en", 32'(cnt_en), 0);
      chk("reset_pdata", 32'(p_data), 0);
      chk("reset_dv", 32'(dv), 0);
      rst = 1'b0;
      step(3);

      // Illegal prescale: low line must not start a frame
      prescale = 5'd12;
      rx = 1'b0;
      step(4);
      chk("illegal_prescale_idle", 32'(cnt_en), 0);
      rx = 1'b1;
      step(2);
      prescale = 5'd16;
      step(2);

      // P=16, no parity, 0xA5
      s = cyc;
      sched_frame(s, 16, 1'b0, 8'hA5, 1'b0, 1'b1, tr);
      chk("t1_model_cycle", tr, s + 161);
      send(8'hA5, 1'b0, 1'b0, 1'b1, 16);
      at(s + 161);
      chk("t1_dv", 32'(dv), 1);
      chk("t1_pdata", 32'(p_data), 32'h A5);
      chk("t1_errs", 32'({pe, se}), 0);
      step(4);

      // P=8, even parity, 0x3C good then bad parity
      prescale = 5'd8;
      par_en = 1'b1;
      par_typ = 1'b0;
      step(2);
      s = cyc;
      sched_frame(s, 8, 1'b1, 8'h3C, 1'b0, 1'b1, tr);
      chk("t2_model_cycle", tr, s + 89);
      send(8'h3C, 1'b1, 1'b0, 1'b1, 8);
      at(s + 89);
      chk("t2_dv", 32'(dv), 1);
      chk("t2_pdata", 32'(p_data), 32'h3C);
      step(4);
      s = cyc;
      sched_frame(s, 8, 1'b1, 8'h3C, 1'b1, 1'b1, tr);
      send(8'h3C, 1'b1, 1'b1, 1'b1, 8);
      at(s + 89);
      chk("t2b_par_err", 32'(pe), 1);
      chk("t2b_no_dv", 32'({dv, se}), 0);
      chk("t2b_pdata_held", 32'(p_data), 32'h3C);
      step(4);

      // P=16, stop bit 0
      prescale = 5'd16;
      par_en = 1'b0;
      step(2);
      s = cyc;
      sched_frame(s, 16, 1'b0, 8'h33, 1'b0, 1'b0, tr);
      send(8'h33, 1'b0, 1'b0, 1'b0, 16);
      at(s + 161);
      chk("t3_stp_err", 32'(se), 1);
      chk("t3_no_dv", 32'({dv, pe}), 0);
      step(1);
      chk("t3_idle_after", 32'(cnt_en), 0);
      step(4);

      // Start glitch, 4 cycles low at P=16
      s = cyc;
      sched_glitch(s, 4, 16, tr);
      chk("t4_model_idle", tr, s + 17);
      rx = 1'b0;
      step(4);
      rx = 1'b1;
      at(s + 16);
      chk("t4_busy_at_bit_end", 32'(cnt_en), 1);
      step(1);
      chk("t4_abort_idle", 32'(cnt_en), 0);
      step(20);

      // Reset in the middle of data bit_cnt=4
      s = cyc;
      r = s + 4 * 16 + 8;
      sched_frame(s, 16, 1'b0, 8'h5A, 1'b0, 1'b1, tr);
      abort_from(r);
      rx = 1'b0;
      step(16);
      for (int i = 0; i < 4; i++) begin
         rx = (i % 2 == 1);
         step((i == 3) ? 8 : 16);
      end
      chk("t5_bit_cnt_before", 32'(bit_cnt), 4);
      rst = 1'b1;
      rx = 1'b1;
      #1;
      chk("t5_rst_cnt_en", 32'(cnt_en), 0);
      chk("t5_rst_pdata", 32'(p_data), 0);
      chk("t5_rst_pulses", 32'({dv, pe, se}), 0);
      step(2);
      rst = 1'b0;
      step(3);
      s = cyc;
      sched_frame(s, 16, 1'b0, 8'h5A, 1'b0, 1'b1, tr);
      send(8'h5A, 1'b0, 1'b0, 1'b1, 16);
      at(tr);
      chk("t5_fresh_dv", 32'(dv), 1);
      chk("t5_fresh_pdata", 32'(p_data), 32'h5A);
      step(4);

      // P=8 back-to-back 0x81 then 0x7E, no idle gap
      prescale = 5'd8;
      step(2);
      s = cyc;
      sched_frame(s, 8, 1'b0, 8'h81, 1'b0, 1'b1, tr);
      sched_frame(s + 80, 8, 1'b0, 8'h7E, 1'b0, 1'b1, tr2);
      chk("t6_model_first", tr, s + 81);
      chk("t6_model_second", tr2, s + 162);
      send(8'h81, 1'b0, 1'b0, 1'b1, 8);
      send(8'h7E, 1'b0, 1'b0, 1'b1, 8);
      at(tr2);
      chk("t6_dv2", 32'(dv), 1);
      chk("t6_pdata2", 32'(p_data), 32'h7E);
      step(5);

      run = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
